// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: multiply/divide opcodes and the muldiv sequencer states.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per live edge.
// Results: multiply -> {res_hi,res_lo} = product; divide -> res_hi = remainder, res_lo = quotient.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count;
    logic             mode_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // The remainder is always below the divisor, so the subtraction result fits in WIDTH bits.
    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, {WIDTH{low[0]}} & mcand};
        div_shift = {acc, low[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - mcand;
        div_ge    = div_shift >= {1'b0, mcand};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clk_enable) begin
            if (load) begin
                count <= CW'(WIDTH);
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (load) begin
                acc      <= '0;
                low      <= is_div ? op_a : op_b;
                mcand    <= is_div ? op_b : op_a;
                mode_div <= is_div;
            end else if (count != '0) begin
                if (mode_div) begin
                    acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    low <= {low[WIDTH-2:0], div_ge};
                end else begin
                    acc <= mul_sum[WIDTH:1];
                    low <= {mul_sum[0], low[WIDTH-1:1]};
                end
            end
        end
    end

    assign res_hi = acc;
    assign res_lo = low;
    assign last   = (count == CW'(1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS multiply/divide unit with HI/LO registers, iterative engine plus sign fixup stage.
// Define MULDIV_FAST_MUL_EN to complete MULT/MULTU in a single cycle with a native multiplier.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mips_cpu_pkg::*;

    muldiv_state_t    state, state_next;
    logic             busy_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             core_load, core_is_div, core_last;
    logic [WIDTH-1:0] core_a, core_b, res_hi, res_lo;
    logic             signed_op, rs_neg, rt_neg;
    logic             neg_res, neg_rem, div_zero, fix_div;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic n, input logic [2*WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    function automatic logic [2*WIDTH-1:0] fast_mul(input logic sgn, input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ea, eb;
        ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction
`endif

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .load       (core_load),
        .is_div     (core_is_div),
        .op_a       (core_a),
        .op_b       (core_b),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .last       (core_last)
    );

    // Signed ops run on magnitudes; the signs are reapplied in FIX.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        rs_neg    = signed_op & rs_val[WIDTH-1];
        rt_neg    = signed_op & rt_val[WIDTH-1];
        core_a    = signed_op ? abs_val(rs_val) : rs_val;
        core_b    = signed_op ? abs_val(rt_val) : rt_val;
    end

    always_comb begin
        state_next  = state;
        busy_next   = busy;
        hi_next     = hi;
        lo_next     = lo;
        core_load   = 1'b0;
        core_is_div = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_next = rs_val;
                        OP_MTLO: lo_next = rs_val;
                        OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi_next, lo_next} = fast_mul(signed_op, rs_val, rt_val);
`else
                            core_load  = 1'b1;
                            state_next = S_MUL;
                            busy_next  = 1'b1;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            core_load   = 1'b1;
                            core_is_div = 1'b1;
                            state_next  = S_DIV;
                            busy_next   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (core_last) state_next = S_FIX;
            end
            S_FIX: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                if (fix_div) begin
                    // Divide by zero leaves |rs| as remainder; only the quotient needs forcing.
                    lo_next = div_zero ? '1 : neg_if(neg_res, res_lo);
                    hi_next = neg_if(neg_rem, res_hi);
                end else begin
                    {hi_next, lo_next} = neg_if2(neg_res, {res_hi, res_lo});
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (clk_enable) begin
            state <= state_next;
            busy  <= busy_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable && core_load) begin
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= (rt_val == '0);
            fix_div  <= core_is_div;
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32, default iterative multiply build).
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_enable;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one instruction, computed with plain integer arithmetic.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] h0, input logic [31:0] l0,
                                      output logic [31:0] h, output logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        int          ia, ib;
        ia = int'(a);
        ib = int'(b);
        h  = h0;
        l  = l0;
        case (o)
            3'd0: begin
                sp = longint'(ia) * longint'(ib);
                {h, l} = sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            3'd2: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'd0;
                end else begin
                    l = ia / ib; h = ia % ib;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, optionally stall or inject a busy-time MTHI, then check latency and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int stall_at, input int stall_len,
                          input int mthi_at);
        logic [31:0] eh, el;
        int          cyc, exp_cyc;
        bit          held;
        ref_model(o, a, b, model_hi, model_lo, eh, el);
        exp_cyc = (o <= 3'd3) ? W + 1 + stall_len : 0;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        cyc = 0;
        held = 1'b1;
        while (busy === 1'b1 && cyc < 200) begin
            clk_enable = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == mthi_at) begin
                start = 1'b1; op = 3'd4; rs_val = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1 && (hi !== model_hi || lo !== model_lo)) held = 1'b0;
        end
        clk_enable = 1'b1;
        start = 1'b0;
        check({tag, " busy_cycles"}, cyc, exp_cyc);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " hold"}, held, 1);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b0;

        run_op("mthi", 3'd4, 32'hA5A5_A5A5, 32'd0, -1, 0, -1);
        run_op("mtlo", 3'd5, 32'h5A5A_5A5A, 32'd0, -1, 0, -1);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 0, -1);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 0, -1);
        run_op("divu_small", 3'd3, 32'd7, 32'd2, -1, 0, -1);
        run_op("div_zero", 3'd2, 32'h0000_1234, 32'd0, -1, 0, -1);
        run_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0, -1, 0, -1);
        run_op("divu_zero", 3'd3, 32'h8765_4321, 32'd0, -1, 0, -1);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, -1, 0, -1);
        run_op("undef_op", 3'd6, 32'h1111_1111, 32'h2222_2222, -1, 0, -1);
        run_op("divu_stall", 3'd3, $urandom, $urandom, 7, 5, -1);
        run_op("mult_stall", 3'd0, $urandom, $urandom, 20, 3, -1);
        run_op("mthi_busy", 3'd2, $urandom, $urandom, -1, 0, 5);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), -1, 0, -1);
        end

        // Reset during a divide, with clk_enable low, must still clear everything.
        op = 3'd3; rs_val = $urandom; rt_val = $urandom | 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midop busy", busy, 1);
        reset = 1'b1; clk_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; clk_enable = 1'b1;
        check("midop reset busy", busy, 0);
        check("midop reset hi", hi, 0);
        check("midop reset lo", lo, 0);
        model_hi = '0;
        model_lo = '0;

        run_op("post_reset_mult", 3'd0, $urandom, $urandom, -1, 0, -1);
        run_op("post_reset_div", 3'd2, pick(), pick(), -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
